fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: compacting circular instruction FIFO between fetch and decode; define FETCH_QUEUE_BYPASS_EN for same-cycle empty-queue bypass
`ifndef SUPER
`define SUPER 2
`endif
module fetch_queue #(
   parameter int SUPER = `SUPER,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SUPER*65-1:0]          f2d,
   output logic                         enq_ready,
   input  logic                         flush,
   output logic [SUPER-1:0]             d_valid,
   output logic [SUPER*32-1:0]          d_pc,
   output logic [SUPER*32-1:0]          d_instr,
   input  logic [$clog2(SUPER+1)-1:0]   deq_cnt,
   output logic [CW-1:0]                count
);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   mem_pc [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   c_pc [SUPER];
   logic [31:0]   c_instr [SUPER];
   logic [SUPER-1:0] we;
   logic [PW-1:0] waddr [SUPER];
   logic          fire, bypass;
   int            enq_n, avail, deq, skip;

   assign enq_ready = count_q <= CW'(DEPTH - SUPER);
   assign count     = count_q;

   // squeeze valid fetch lanes down to a dense prefix; each lane is {pc, instr, valid}
   always_comb begin
      enq_n = 0;
      for (int j = 0; j < SUPER; j++) begin
         c_pc[j]    = '0;
         c_instr[j] = '0;
      end
      for (int i = 0; i < SUPER; i++)
         if (f2d[i*65]) begin
            for (int j = 0; j < SUPER; j++)
               if (j == enq_n) begin
                  c_pc[j]    = f2d[i*65+33 +: 32];
                  c_instr[j] = f2d[i*65+1 +: 32];
               end
            enq_n = enq_n + 1;
         end
   end

   // pointer/occupancy next state; lanes bypassed straight to decode and consumed are never stored
   always_comb begin
      fire = enq_ready && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass = rst && fire && count_q == '0;
`else
      bypass = 1'b0;
`endif
      avail = bypass ? enq_n : (int'(count_q) < SUPER ? int'(count_q) : SUPER);
      deq   = int'(deq_cnt) > avail ? avail : int'(deq_cnt);
      skip  = bypass ? deq : 0;
      for (int j = 0; j < SUPER; j++) begin
         we[j]    = fire && j < enq_n && j >= skip;
         waddr[j] = tail_q + PW'(j - skip);
      end
      head_d  = flush ? '0 : head_q + PW'(deq - skip);
      tail_d  = flush ? '0 : tail_q + (fire ? PW'(enq_n - skip) : '0);
      count_d = flush ? '0 : CW'(int'(count_q) + (fire ? enq_n : 0) - deq);
   end

   // present the oldest entries; lanes beyond occupancy drive zero
   always_comb begin
      for (int i = 0; i < SUPER; i++) begin
         d_valid[i]          = int'(count_q) > i;
         d_pc[i*32 +: 32]    = d_valid[i] ? mem_pc[head_q + PW'(i)] : '0;
         d_instr[i*32 +: 32] = d_valid[i] ? mem_instr[head_q + PW'(i)] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
         if (bypass) begin
            d_valid[i]          = enq_n > i;
            d_pc[i*32 +: 32]    = c_pc[i];
            d_instr[i*32 +: 32] = c_instr[i];
         end
`endif
      end
   end

   // queue pointers and occupancy, cleared asynchronously
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end

   // entry storage, deliberately not reset
   always_ff @(posedge clk)
      for (int j = 0; j < SUPER; j++)
         if (we[j]) begin
            mem_pc[waddr[j]]    <= c_pc[j];
            mem_instr[waddr[j]] <= c_instr[j];
         end

`ifndef SYNTHESIS
   // decode asking for more than is presented is a protocol error; the RTL clamps it
   always_ff @(posedge clk)
      if (rst && !flush && int'(deq_cnt) > avail)
         $error("fetch_queue: deq_cnt %0d exceeds presented %0d", deq_cnt, avail);
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue against a queue-of-entries reference model
module tb_fetch_queue;
   localparam int S = 2, DEPTH = 8, DW = $clog2(S + 1), CW = $clog2(DEPTH + 1);
   typedef struct {
      logic [S-1:0]    v;
      logic [S*32-1:0] pc;
      logic [S*32-1:0] ins;
      int              cnt;
      logic            rdy;
   } exp_t;
   logic clk = 0, rst = 0, flush = 0;
   logic enq_ready;
   logic [S*65-1:0] f2d = '0;
   logic [S-1:0]    d_valid;
   logic [S*32-1:0] d_pc, d_instr;
   logic [DW-1:0]   deq_cnt = '0;
   logic [CW-1:0]   count;
   logic [63:0]     mq[$];
   exp_t            sb[$];
   exp_t            m;
   int              tests = 0, fails = 0;

   always #5 clk = ~clk;

   fetch_queue #(.SUPER(S), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .f2d(f2d), .enq_ready(enq_ready), .flush(flush),
      .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .deq_cnt(deq_cnt), .count(count)
   );

   function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endfunction

   function automatic logic [S*65-1:0] bnd(logic [31:0] pc0, logic [S-1:0] v);
      logic [S*65-1:0] b;
      for (int i = 0; i < S; i++) begin
         logic [31:0] p;
         p = pc0 + 32'(4 * i);
         b[i*65 +: 65] = {p, p[15:0], ~p[15:0], v[i]};
      end
      return b;
   endfunction

   // one cycle: record what decode must see now, drive inputs, then advance the model
   task automatic cycle(logic [S*65-1:0] b, logic fl, int dq);
      logic [63:0] lanes[$];
      logic [63:0] pres[$];
      exp_t e;
      bit rdy;
      @(negedge clk);
      for (int i = 0; i < S; i++)
         if (b[i*65]) lanes.push_back(b[i*65+1 +: 64]);
      rdy = mq.size() <= DEPTH - S;
      pres = mq;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (mq.size() == 0 && !fl) pres = lanes;
`endif
      e.v = '0;
      e.pc = '0;
      e.ins = '0;
      e.cnt = mq.size();
      e.rdy = rdy;
      for (int i = 0; i < S && i < pres.size(); i++) begin
         e.v[i] = 1'b1;
         e.pc[i*32 +: 32] = pres[i][63:32];
         e.ins[i*32 +: 32] = pres[i][31:0];
      end
      if (dq > pres.size()) dq = pres.size();
      sb.push_back(e);
      f2d = b;
      flush = fl;
      deq_cnt = DW'(dq);
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (rdy) foreach (lanes[i]) mq.push_back(lanes[i]);
         repeat (dq) void'(mq.pop_front());
      end
   endtask

   task automatic reset_check(string tag);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_ready"}, enq_ready, 1);
      chk({tag, "_valid"}, d_valid, 0);
      chk({tag, "_pc"}, d_pc, 0);
   endtask

   always @(negedge clk) begin
      #2;
      if (sb.size() > 0) begin
         m = sb.pop_front();
         chk("d_valid", d_valid, m.v);
         chk("d_pc", d_pc, m.pc);
         chk("d_instr", d_instr, m.ins);
         chk("count", count, m.cnt);
         chk("enq_ready", enq_ready, m.rdy);
      end
   end

   initial begin
      #7;
      reset_check("reset");
      #1 rst = 1;
      cycle(bnd(32'h100, 2'b11), 0, 0);
      cycle('0, 0, 2);
      cycle(bnd(32'h200, 2'b10), 0, 0);
      cycle('0, 0, 1);
      for (int k = 0; k < 3; k++) cycle(bnd(32'h400 + 32'(k * 8), 2'b11), 0, 0);
      cycle(bnd(32'h500, 2'b01), 0, 0);
      cycle(bnd(32'h600, 2'b11), 0, 0);
      cycle('0, 0, 2);
      repeat (4) cycle('0, 0, 2);
      for (int k = 0; k < 2; k++) cycle(bnd(32'h700 + 32'(k * 8), 2'b11), 0, 0);
      cycle(bnd(32'h800, 2'b11), 1, 2);
      cycle(bnd(32'h900, 2'b01), 0, 0);
      cycle('0, 0, 0);
      for (int k = 0; k < 400; k++) begin
         cycle(bnd($urandom & 32'hFFFF_FFFC, S'($urandom)), $urandom_range(0, 19) == 0,
               (k % 64 < 32) ? $urandom_range(0, 1) : $urandom_range(0, S));
         if (k == 200) begin
            #2 rst = 0;
            #1 reset_check("midreset");
            mq.delete();
            #1 rst = 1;
         end
      end
      repeat (3) cycle('0, 0, 0);
      @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
